// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command/response bytes and the host transmitter state type.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_BAT_OK  = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_tx_state_t;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin, plus a one-cycle falling-edge strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the flop chain.
  // Reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= pin;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign level = sync;
  assign fall  = sync_d & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked-out frame, device ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_CLK_I,
  input  logic       PS2_DATA_I,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       EDGE_STOP = 4'd9;   // edges seen before the stop-bit fall
  localparam logic [3:0]       EDGE_MAX  = 4'd11;

  ps2_tx_state_t    state;
  ps2_tx_state_t    state_nxt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       edge_cnt;
  logic             data_oe_q;
  logic             clk_level;
  logic             clk_fall;
  logic             data_meta;
  logic             data_level;
  logic             timeout;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (PS2_CLK_I),
    .level (clk_level),
    .fall  (clk_fall)
  );

  // DATA needs only its synchronized level.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta  <= 1'b1;
      data_level <= 1'b1;
    end else begin
      data_meta  <= PS2_DATA_I;
      data_level <= data_meta;
    end
  end

  assign timeout = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every branch must assign state_nxt; the default up front prevents a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (tx_start) state_nxt = ST_INHIBIT;
      ST_INHIBIT:   if (inh_cnt == INH_LAST) state_nxt = ST_START;
      ST_START:     state_nxt = ST_SEND;
      ST_SEND: begin
        if (timeout)                              state_nxt = ST_ERR;
        else if (clk_fall && edge_cnt == EDGE_STOP) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (timeout)       state_nxt = ST_ERR;
        else if (clk_fall) state_nxt = data_level ? ST_ERR : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timeout)                      state_nxt = ST_ERR;
        else if (clk_level && data_level) state_nxt = ST_DONE;
      end
      ST_DONE:      state_nxt = ST_IDLE;
      ST_ERR:       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      parity_q  <= 1'b0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      edge_cnt  <= '0;
      data_oe_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          inh_cnt <= '0;
          if (tx_start) begin
            data_q   <= tx_data;
            parity_q <= odd_parity(tx_data);
          end
        end
        ST_INHIBIT: inh_cnt <= inh_cnt + 1'b1;
        ST_START: begin
          edge_cnt  <= '0;
          to_cnt    <= '0;
          data_oe_q <= 1'b1;
        end
        ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
          to_cnt <= to_cnt + 1'b1;
          if (clk_fall && edge_cnt != EDGE_MAX) edge_cnt <= edge_cnt + 1'b1;
          // The device samples on CLK rise, so the next bit goes out on each fall.
          if (state == ST_SEND && clk_fall) begin
            if (edge_cnt < 4'd8)       data_oe_q <= ~data_q[edge_cnt[2:0]];
            else if (edge_cnt == 4'd8) data_oe_q <= ~parity_q;
            else                       data_oe_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_busy     = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    PS2_CLK_OE  = 1'b0;
    PS2_DATA_OE = 1'b0;
    unique case (state)
      ST_INHIBIT: begin
        tx_busy    = 1'b1;
        PS2_CLK_OE = 1'b1;
      end
      ST_START: begin
        tx_busy     = 1'b1;
        PS2_CLK_OE  = 1'b1;
        PS2_DATA_OE = 1'b1;
      end
      ST_SEND: begin
        tx_busy     = 1'b1;
        PS2_DATA_OE = data_oe_q;
      end
      ST_ACK, ST_WAIT_IDLE: tx_busy = 1'b1;
      ST_DONE:              tx_done = 1'b1;
      ST_ERR:               tx_err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, …) from the FPGA to the keyboard using the PS/2 host-request sequence, then checks the device's line-level ACK bit. It sits beside the keyboard receive path and shares the two open-drain PS/2 pins with it. While `tx_busy` is high, the top level holds the receiver in reset or ignores it.

## Interface
- `INHIBIT_CYCLES`, default 12_000: cycles CLK is held low to request to send (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 1_500_000: budget from CLK release to ACK sampled (15 ms); exceeding it aborts the transfer.
- `clk`  in  1: system clock, the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `tx_data`  in  8: byte to send; latched when `tx_start` is accepted.
- `tx_start`  in  1: single-cycle request; accepted only while idle (`tx_busy`=0).
- `tx_busy`  out  1: high from the cycle after acceptance until the cycle `tx_done`/`tx_err` pulses.
- `tx_done`  out  1: one-cycle pulse; byte sent and device ACK (DATA=0) seen.
- `tx_err`  out  1: one-cycle pulse; NACK (DATA=1 at ACK slot) or timeout.
- `PS2_CLK_I`  in  1: raw PS/2 clock pin level (asynchronous).
- `PS2_DATA_I`  in  1: raw PS/2 data pin level (asynchronous).
- `PS2_CLK_OE`  out  1: 1 = drive CLK low. Top level: `PS2_CLK = OE ? 0 : z`.
- `PS2_DATA_OE`  out  1: 1 = drive DATA low.

## Operation
- Reset values: `tx_busy`=0, `tx_done`=0, `tx_err`=0, `PS2_CLK_OE`=0, `PS2_DATA_OE`=0, state IDLE, counters 0.
- Pin inputs pass through a 2-flop synchronizer. A falling edge of synced CLK produces a one-cycle `fall` strobe.
- Frame: start bit 0, `tx_data[0..7]` LSB first, odd parity (`~^tx_data`), stop bit 1, then a device ACK bit.
- **IDLE**: both OE=0. On `tx_start` it latches the byte and computes parity, then goes to INHIBIT.
- **INHIBIT**: `CLK_OE`=1, `DATA_OE`=0, counting `INHIBIT_CYCLES` cycles. Then it goes to START.
- **START** (1 cycle): `CLK_OE`=1, `DATA_OE`=1 (start bit). It clears the edge count and the timeout counter, then goes to SEND.
- **SEND**: `CLK_OE`=0, so the device now clocks. Each `fall` increments edge count n:
  - n=1..8 → `DATA_OE` = ~data[n-1].
  - n=9 → `DATA_OE` = ~parity.
  - n=10 → `DATA_OE`=0 (stop bit, line released). Go to ACK.
- **ACK**: on the next `fall`, sample synced DATA. 0 → WAIT_IDLE. 1 → ERR.
- **WAIT_IDLE**: wait until synced CLK=1 and DATA=1, then go to DONE.
- **DONE** / **ERR** (1 cycle): pulse `tx_done` / `tx_err`, `tx_busy`=0, both OE=0, return to IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. On reaching `TIMEOUT_CYCLES`, go to ERR. The lines are released in the same cycle the state changes.
- `tx_start` while busy is ignored, with no queueing. `tx_start` in the DONE/ERR cycle is also ignored.
- `rst` mid-transfer: the next cycle both OE=0, all outputs take their reset values, and no done/err pulse is generated.
- `fall` strobes seen in IDLE, INHIBIT or START are ignored; keyboard traffic racing the inhibit is the device's job to abort.
- Counters are sized with `$clog2` of their parameter. The edge count is 4 bits and saturates at 11.

## Timing
- `tx_start` at cycle 0:
  - `tx_busy`=1 and `CLK_OE`=1 from cycle 1.
  - `DATA_OE`=1 at cycle 1+`INHIBIT_CYCLES`.
  - `CLK_OE`=0 from cycle 2+`INHIBIT_CYCLES`.
- Pin fall to `DATA_OE` update: 3 cycles (2 for the synchronizer, 1 for the register). This is well inside the ≥30 µs CLK-low half period.
- ACK to `tx_done`: WAIT_IDLE ends 3 cycles after both pins are observed high; `tx_done` pulses on the following cycle.
- `tx_done` and `tx_err` never assert together. Each is exactly 1 cycle wide, coincident with `tx_busy` falling.

## Structure
- Package `ps2_pkg` holds:
  - command constants: `PS2_CMD_SET_LED`=8'hED, `PS2_CMD_RESET`=8'hFF, `PS2_CMD_ENABLE`=8'hF4;
  - response constants: `PS2_RSP_ACK`=8'hFA, `PS2_RSP_BAT_OK`=8'hAA;
  - the state enum typedef `ps2_tx_state_t`.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus falling-edge strobe. It is instantiated for CLK; for DATA only the synced level is used.

## Test plan
Bench parameters: `INHIBIT_CYCLES`=20, `TIMEOUT_CYCLES`=4000. A device model drives a 40-cycle-period clock and samples DATA on each CLK rise.
- Send 0xED, model ACKs → model captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1; `tx_done` pulses once; `tx_busy` spans start to done; no `tx_err`.
- Send 0x01 (parity 0) and 0x00 (parity 1), both ACKed → correct parity captured each time; `DATA_OE`=1 asserted at exactly cycle 21.
- Model holds DATA high in the ACK slot → `tx_err` pulses; both OE=0; `tx_done` never asserts.
- Model never clocks after START → `tx_err` exactly 4000 cycles after START; both OE=0 in that cycle.
- Pulse `tx_start` with 0x55 mid-SEND of 0xFF → ignored; model receives 0xFF only.
- Assert `rst` at edge 5 → next cycle both OE=0 and `tx_busy`=0; no pulses. A fresh send of 0xF4 then completes with `tx_done`.
